// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ceiling log2, minimum 1 so a 2-port arbiter still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, modulo N.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  // Rotate req so that bit ptr lands at position 0.
  always_comb begin
    int unsigned j;
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = i + 32'(ptr);
      if (j >= N) j = j - N;
      rot[i] = req[j];
    end
  end

  // Fixed priority on the rotated vector, lowest bit wins.
  always_comb begin
    any = 1'b0;
    off = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !any) begin
        any = 1'b1;
        off = IW'(i);
      end
    end
  end

  // Un-rotate the winning offset back to an absolute port number.
  always_comb begin
    int unsigned s;
    s = 32'(off) + 32'(ptr);
    if (s >= N) s = s - N;
    win = '0;
    idx = '0;
    if (any) begin
      win = N'(1) << s;
      idx = IW'(s);
    end
  end

endmodule

// File: rtl/rr_arb_weighted.sv
// Weighted round-robin arbiter: an owner keeps the grant for up to weight
// consecutive transactions while it keeps requesting, then priority rotates.
module rr_arb_weighted
  import rr_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int WW = 4,
  localparam int IW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_d;
  logic [IW-1:0] idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] credit_q, credit_d;

  logic [IW-1:0] ptr_after_owner;
  logic [IW-1:0] pick_ptr;
  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic [WW-1:0] win_weight;
  logic [WW-1:0] load_credit;
  logic          keep_owner;

  assign gnt_valid = |gnt;

  // On a BUSY handover the search must already start past the current owner,
  // so the picker is fed the advanced pointer in that state.
  always_comb begin
    ptr_after_owner = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    pick_ptr        = (state_q == BUSY) ? ptr_after_owner : ptr_q;
    keep_owner      = done && req[gnt_idx] && (credit_q != '0);
    win_weight      = weight[32'(win_idx) * WW +: WW];
    load_credit     = (win_weight == '0) ? '0 : win_weight - WW'(1);
  end

  rr_arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .win (win),
    .idx (win_idx),
    .any (win_any)
  );

  // Next-state, grant and credit decisions.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    idx_d    = gnt_idx;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d  = BUSY;
          gnt_d    = win;
          idx_d    = win_idx;
          credit_d = load_credit;
        end
      end
      BUSY: begin
        if (done) begin
          if (keep_owner) begin
            credit_d = credit_q - WW'(1);
          end else begin
            ptr_d = ptr_after_owner;
            if (win_any) begin
              gnt_d    = win;
              idx_d    = win_idx;
              credit_d = load_credit;
            end else begin
              state_d  = IDLE;
              gnt_d    = '0;
              idx_d    = '0;
              credit_d = '0;
            end
          end
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        idx_d    = '0;
        credit_d = '0;
      end
    endcase
  end

  // State, grant, pointer and credit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      gnt_idx  <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

endmodule
